nes_scandoubler: RTL and testbench

Line-doubling stage between the NES video encoder and the VGA/analog output pins. It captures each 15 kHz input line (pixel strobe every other `clk`) into a ping-pong line buffer and replays it twice at full `clk` rate, producing 31 kHz output with optional scanline darkening. When disabled it passes the encoder output through with one register stage.

---
 rtl/scandoubler_pkg.sv | 31 +++
 rtl/nes_scandoubler_line_buffer.sv | 24 ++
 rtl/nes_scandoubler.sv | 168 ++++++++++++++++
 tb/tb_nes_scandoubler.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/scandoubler_pkg.sv
// Shared pixel type, scanline modes and default line geometry for the NES line doubler.
package scandoubler_pkg;

   typedef struct packed {
      logic [7:0] r;
      logic [7:0] g;
      logic [7:0] b;
   } rgb_t;

   typedef enum logic [1:0] {
      SL_OFF = 2'd0,
      SL_25  = 2'd1,
      SL_50  = 2'd2,
      SL_75  = 2'd3
   } sl_mode_t;

   localparam int unsigned DEF_LINE_PIX = 512;
   localparam int unsigned DEF_LINE_LEN = 682;
   localparam int unsigned DEF_HS_START = 556;
   localparam int unsigned DEF_HS_END   = 606;

   function automatic logic [7:0] shade(input logic [7:0] c, input sl_mode_t m);
      case (m)
         SL_25:   return c - (c >> 2);
         SL_50:   return c >> 1;
         SL_75:   return c >> 2;
         default: return c;
      endcase
   endfunction

endpackage

// File: rtl/nes_scandoubler_line_buffer.sv
// Ping-pong line store: two banks of DEPTH pixels, bank bit is the address MSB, registered read.
module line_buffer
   import scandoubler_pkg::*;
#(
   parameter  int unsigned DEPTH = DEF_LINE_PIX,
   localparam int unsigned AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW:0]   wr_addr,
   input  logic [23:0]   wr_data,
   input  logic [AW:0]   rd_addr,
   output logic [23:0]   rd_data
);

   logic [23:0] mem [0:(2**(AW+1))-1];

   always_ff @(posedge clk) begin
      if (we)
         mem[wr_addr] <= wr_data;
      rd_data <= mem[rd_addr];
   end

endmodule

// File: rtl/nes_scandoubler.sv
// 15 kHz -> 31 kHz line doubler with scanline darkening and a registered passthrough mode.
module nes_scandoubler
   import scandoubler_pkg::*;
#(
   parameter int unsigned LINE_PIX = DEF_LINE_PIX,
   parameter int unsigned LINE_LEN = DEF_LINE_LEN,
   parameter int unsigned HS_START = DEF_HS_START,
   parameter int unsigned HS_END   = DEF_HS_END
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       ce_pix,
   input  logic       enable,
   input  logic [1:0] scanlines,
   input  logic [7:0] r_in,
   input  logic [7:0] g_in,
   input  logic [7:0] b_in,
   input  logic       hs_in,
   input  logic       vs_in,
   input  logic       hblank_in,
   input  logic       vblank_in,
   output logic [7:0] r_out,
   output logic [7:0] g_out,
   output logic [7:0] b_out,
   output logic       hs_out,
   output logic       vs_out,
   output logic       hblank_out,
   output logic       vblank_out,
   output logic       ce_out
);

   localparam int unsigned AW = $clog2(LINE_PIX);
   localparam int unsigned HW = $clog2(LINE_LEN);
   localparam logic [AW:0]   W_PIX  = (AW+1)'(LINE_PIX);
   localparam logic [AW:0]   W_ONE  = (AW+1)'(1);
   localparam logic [HW-1:0] H_PIX  = HW'(LINE_PIX);
   localparam logic [HW-1:0] H_LAST = HW'(LINE_LEN - 1);
   localparam logic [HW-1:0] H_ONE  = HW'(1);
   localparam logic [HW-1:0] H_HS0  = HW'(HS_START);
   localparam logic [HW-1:0] H_HS1  = HW'(HS_END);

   logic          hb_prev, vb_prev, wr_bank, rd_bank, cap_vs, cap_vb, mode;
   logic [AW:0]   wr_addr;
   logic [HW-1:0] h_out;
   logic          odd, line_vs, line_vb;
   logic          s1_blank, s1_vb, s1_vs, s1_hs, s1_odd;
   logic [23:0]   rd_data;
   rgb_t          rd_pix, pix;
   sl_mode_t      sl;

   logic line_event, hb_rise, vb_rise, we, wbank;
   assign line_event = ce_pix & hb_prev & ~hblank_in;
   assign hb_rise    = ce_pix & ~hb_prev & hblank_in;
   assign vb_rise    = ce_pix & ~vb_prev & vblank_in;
   assign we         = ce_pix & ~hblank_in & (wr_addr < W_PIX);
   // Pixel 0 arrives on the event strobe itself, so it lands in the bank being switched to.
   assign wbank      = wr_bank ^ line_event;

   line_buffer #(.DEPTH(LINE_PIX)) u_buf (
      .clk     (clk),
      .we      (we),
      .wr_addr ({wbank, wr_addr[AW-1:0]}),
      .wr_data ({r_in, g_in, b_in}),
      .rd_addr ({rd_bank, h_out[AW-1:0]}),
      .rd_data (rd_data)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         hb_prev <= 1'b1;
         vb_prev <= 1'b1;
         wr_addr <= '0;
         wr_bank <= 1'b0;
         rd_bank <= 1'b1;
         cap_vs  <= 1'b0;
         cap_vb  <= 1'b1;
         mode    <= 1'b1;
         h_out   <= '0;
         odd     <= 1'b0;
         line_vs <= 1'b0;
         line_vb <= 1'b1;
      end else begin
         if (ce_pix) begin
            hb_prev <= hblank_in;
            vb_prev <= vblank_in;
            if (hblank_in)
               wr_addr <= '0;
            else if (wr_addr < W_PIX)
               wr_addr <= wr_addr + W_ONE;
         end
         if (hb_rise) begin
            cap_vs <= vs_in;
            cap_vb <= vblank_in;
         end
         if (vb_rise)
            mode <= enable;
         if (line_event) begin
            wr_bank <= ~wr_bank;
            rd_bank <= wr_bank;
            h_out   <= '0;
            odd     <= 1'b0;
            line_vs <= cap_vs;
            line_vb <= cap_vb;
         end else if (h_out == H_LAST) begin
            h_out <= '0;
            odd   <= ~odd;
         end else begin
            h_out <= h_out + H_ONE;
         end
      end
   end

   always_comb begin
      rd_pix = rgb_t'(rd_data);
      sl     = s1_odd ? sl_mode_t'(scanlines) : SL_OFF;
      pix.r  = shade(rd_pix.r, sl);
      pix.g  = shade(rd_pix.g, sl);
      pix.b  = shade(rd_pix.b, sl);
      if (s1_blank || s1_vb)
         pix = '0;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s1_blank   <= 1'b1;
         s1_vb      <= 1'b1;
         s1_vs      <= 1'b0;
         s1_hs      <= 1'b0;
         s1_odd     <= 1'b0;
         r_out      <= '0;
         g_out      <= '0;
         b_out      <= '0;
         hs_out     <= 1'b0;
         vs_out     <= 1'b0;
         hblank_out <= 1'b1;
         vblank_out <= 1'b1;
         ce_out     <= 1'b0;
      end else begin
         s1_blank <= ~(h_out < H_PIX);
         s1_vb    <= line_vb;
         s1_vs    <= line_vs;
         s1_hs    <= (h_out >= H_HS0) && (h_out < H_HS1);
         s1_odd   <= odd;
         if (mode) begin
            ce_out     <= 1'b1;
            r_out      <= pix.r;
            g_out      <= pix.g;
            b_out      <= pix.b;
            hs_out     <= s1_hs;
            vs_out     <= s1_vs;
            hblank_out <= s1_blank;
            vblank_out <= s1_vb;
         end else begin
            ce_out <= ce_pix;
            if (ce_pix) begin
               r_out      <= r_in;
               g_out      <= g_in;
               b_out      <= b_in;
               hs_out     <= hs_in;
               vs_out     <= vs_in;
               hblank_out <= hblank_in;
               vblank_out <= vblank_in;
            end
         end
      end
   end

endmodule

// File: tb/tb_nes_scandoubler.sv
// Directed bench for nes_scandoubler: a 682-strobe line source plus per-feature checking tasks.
module tb_nes_scandoubler;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       ce_pix, enable = 1'b1;
   logic [1:0] scanlines = 2'd0;
   logic [7:0] r_in, g_in, b_in;
   logic       hs_in, vs_in, hblank_in, vblank_in;
   logic [7:0] r_out, g_out, b_out;
   logic       hs_out, vs_out, hblank_out, vblank_out, ce_out;

   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;

   // source control (line layout: 512 active strobes, then 170 blanking strobes)
   int src_x = 512;
   bit src_first = 1'b0;
   bit src_const = 1'b0;
   bit cur_const = 1'b0, cur_vs = 1'b0, cur_vb = 1'b0;
   int vs_req_n = 0, vb_req_n = 0;
   int freeze_req = 0, freeze_cnt = 0;

   nes_scandoubler dut (
      .clk(clk), .reset_n(reset_n), .ce_pix(ce_pix), .enable(enable), .scanlines(scanlines),
      .r_in(r_in), .g_in(g_in), .b_in(b_in),
      .hs_in(hs_in), .vs_in(vs_in), .hblank_in(hblank_in), .vblank_in(vblank_in),
      .r_out(r_out), .g_out(g_out), .b_out(b_out),
      .hs_out(hs_out), .vs_out(vs_out), .hblank_out(hblank_out), .vblank_out(vblank_out),
      .ce_out(ce_out)
   );

   initial forever #5 clk = ~clk;

   initial begin : source
      logic [7:0] xv;
      bit adv;
      ce_pix = 1'b0; hblank_in = 1'b1; vblank_in = 1'b0; vs_in = 1'b0; hs_in = 1'b0;
      r_in = '0; g_in = '0; b_in = '0;
      forever begin
         @(posedge clk); #1;
         if (src_x == 0) begin
            cur_vs = (vs_req_n > 0);
            if (vs_req_n > 0) vs_req_n--;
            cur_vb = (vb_req_n > 0);
            if (vb_req_n > 0) vb_req_n--;
            cur_const = src_const;
         end
         if (src_x == 512 && freeze_req > 0) begin
            freeze_cnt = freeze_req;
            freeze_req = 0;
         end
         xv  = 8'(src_x);
         adv = (freeze_cnt == 0);
         ce_pix = 1'b1; vs_in = cur_vs; vblank_in = cur_vb;
         src_first = adv && (src_x == 0);
         if (!adv) begin
            hblank_in = 1'b1; hs_in = 1'b0; {r_in, g_in, b_in} = 24'h0;
            freeze_cnt--;
         end else begin
            hblank_in = (src_x >= 512);
            hs_in     = (src_x >= 556 && src_x < 606);
            {r_in, g_in, b_in} = cur_const ? 24'hC8C8C8 : {xv, ~xv, 8'h55};
         end
         @(posedge clk); #1;
         ce_pix = 1'b0;
         if (adv) src_x = (src_x == 681) ? 0 : src_x + 1;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // returns at the posedge where the DUT samples the first active strobe of a line
   task automatic wait_ev();
      int unsigned n = 0;
      do begin
         @(posedge clk);
         n++;
      end while (!(ce_pix && src_first) && n < 20000);
      if (!(ce_pix && src_first)) begin
         n_cmp++; n_bad++;
         $display("FAIL wait_ev: no line start within %0d clk", n);
      end
   endtask

   task automatic test_reset();
      logic [28:0] got, exp;
      reset_n = 1'b0;
      repeat (40) @(negedge clk);
      got = {r_out, g_out, b_out, hblank_out, vblank_out, hs_out, vs_out, ce_out};
      exp = {24'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      n_cmp++;
      if (got !== exp) begin n_bad++; $display("FAIL reset_state: got %h want %h", got, exp); end
      reset_n = 1'b1;
      wait_ev();
      repeat (103) @(negedge clk);
      got = {r_out, g_out, b_out, hblank_out, vblank_out, hs_out, vs_out, ce_out};
      exp = {24'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
      n_cmp++;
      if (got !== exp) begin n_bad++; $display("FAIL first_line_black: got %h want %h", got, exp); end
      wait_ev();
      repeat (2) @(negedge clk);
      got = {r_out, g_out, b_out, hblank_out, vblank_out, hs_out, vs_out, ce_out};
      exp = {24'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
      n_cmp++;
      if (got !== exp) begin n_bad++; $display("FAIL pre_first_pixel: got %h want %h", got, exp); end
      @(negedge clk);
      got = {r_out, g_out, b_out, hblank_out, vblank_out, hs_out, vs_out, ce_out};
      exp = {24'h00FF55, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      n_cmp++;
      if (got !== exp) begin n_bad++; $display("FAIL first_pixel: got %h want %h", got, exp); end
   endtask

   task automatic test_ramp();
      logic [28:0] got, exp;
      logic [7:0]  hv;
      int h;
      wait_ev();
      for (int m = 0; m < 1366; m++) begin
         @(negedge clk);
         if (m >= 2) begin
            h  = (m - 2) % 682;
            hv = 8'(h);
            exp = {(h < 512) ? {hv, ~hv, 8'h55} : 24'h0, h >= 512, 1'b0,
                   (h >= 556 && h < 606), 1'b0, 1'b1};
            got = {r_out, g_out, b_out, hblank_out, vblank_out, hs_out, vs_out, ce_out};
            n_cmp++;
            if (got !== exp) begin
               n_bad++; $display("FAIL ramp m=%0d h=%0d: got %h want %h", m, h, got, exp);
            end
         end
      end
   endtask

   task automatic test_scanlines();
      logic [7:0] dark;
      wait_ev();
      src_const = 1'b1;
      wait_ev();
      for (int s = 1; s <= 3; s++) begin
         scanlines = 2'(s);
         case (s)
            1:       dark = 8'h96;
            2:       dark = 8'h64;
            default: dark = 8'h32;
         endcase
         wait_ev();
         repeat (103) @(negedge clk);
         n_cmp++;
         if ({r_out, g_out, b_out} !== 24'hC8C8C8) begin
            n_bad++; $display("FAIL scan_even sl=%0d: got %h want c8c8c8", s, {r_out, g_out, b_out});
         end
         repeat (682) @(negedge clk);
         n_cmp++;
         if ({r_out, g_out, b_out} !== {dark, dark, dark}) begin
            n_bad++;
            $display("FAIL scan_odd sl=%0d: got %h want %h", s, {r_out, g_out, b_out}, {dark, dark, dark});
         end
      end
   endtask

   task automatic test_freerun();
      logic [28:0] got, exp;
      int j, h, od;
      scanlines = 2'd2;
      wait_ev();
      freeze_req = 2487;  // next edge arrives 6338 clk later, mid odd line at h=199
      for (int m = 0; m < 6346; m++) begin
         @(negedge clk);
         if (m >= 2) begin
            j = m - 2;
            if (j < 6338) begin h = j % 682; od = (j / 682) % 2; end
            else begin h = j - 6338; od = 0; end
            exp = {(h >= 512) ? 24'h0 : (od != 0) ? 24'h646464 : 24'hC8C8C8, h >= 512, 1'b0,
                   (h >= 556 && h < 606), 1'b0, 1'b1};
            got = {r_out, g_out, b_out, hblank_out, vblank_out, hs_out, vs_out, ce_out};
            n_cmp++;
            if (got !== exp) begin
               n_bad++; $display("FAIL freerun m=%0d h=%0d odd=%0d: got %h want %h", m, h, od, got, exp);
            end
         end
      end
   endtask

   task automatic test_vsync();
      int first_hi = -1, last_hi = -1, cnt = 0;
      wait_ev();
      vs_req_n = 3;
      wait_ev();
      for (int m = 0; m < 6820; m++) begin
         @(negedge clk);
         if (vs_out === 1'b1) begin
            cnt++;
            if (first_hi < 0) first_hi = m;
            last_hi = m;
         end
      end
      n_cmp++;
      if (first_hi != 1366) begin n_bad++; $display("FAIL vs_start: got %0d want 1366", first_hi); end
      n_cmp++;
      if (last_hi != 5457) begin n_bad++; $display("FAIL vs_end: got %0d want 5457", last_hi); end
      n_cmp++;
      if (cnt != 4092) begin n_bad++; $display("FAIL vs_len: got %0d want 4092", cnt); end
   endtask

   task automatic test_enable();
      logic [28:0] got, exp;
      logic [7:0]  kv;
      bit got_v = 1'b0;
      src_const = 1'b0;
      wait_ev();
      repeat (300) @(negedge clk);
      enable = 1'b0;
      for (int i = 0; i < 1500; i++) begin
         @(negedge clk);
         n_cmp++;
         if (ce_out !== 1'b1) begin n_bad++; $display("FAIL mode_hold i=%0d: ce_out %b want 1", i, ce_out); end
      end
      vb_req_n = 2;
      for (int i = 0; i < 4000 && !got_v; i++) begin
         @(posedge clk);
         if (ce_pix && vblank_in) got_v = 1'b1;
         else begin
            @(negedge clk);
            n_cmp++;
            if (ce_out !== 1'b1) begin n_bad++; $display("FAIL mode_wait i=%0d: ce_out %b want 1", i, ce_out); end
         end
      end
      n_cmp++;
      if (!got_v) begin
         n_bad++; $display("FAIL vblank_rise: no vblank_in rise within 4000 clk");
      end else begin
         for (int m = 0; m < 41; m++) begin
            @(negedge clk);
            if (m == 1) begin
               n_cmp++;
               if (ce_out !== 1'b0) begin n_bad++; $display("FAIL pass_ce m=1: got %b want 0", ce_out); end
            end else if (m >= 2) begin
               kv  = 8'(m / 2);
               exp = {kv, ~kv, 8'h55, 1'b0, 1'b1, 1'b0, 1'b0, (m % 2) == 0};
               got = {r_out, g_out, b_out, hblank_out, vblank_out, hs_out, vs_out, ce_out};
               n_cmp++;
               if (got !== exp) begin
                  n_bad++; $display("FAIL passthrough m=%0d: got %h want %h", m, got, exp);
               end
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_ramp();
      test_scanlines();
      test_freerun();
      test_vsync();
      test_enable();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
